// File: rtl/reaction_timer_multi.sv
// reaction_timer_multi
//   Multi-player reaction-time tester. A rising edge on start arms a
//   pseudo-random delay; when it expires the stimulus LED lights and each
//   player's first stop edge latches the running millisecond count. Early
//   presses are fouls. Completed trials feed min/max/average statistics
//   over player 0, with the average from a bit-serial restoring divider.
// Ports
//   clk_50M      in   system clock, rising edge
//   clear        in   synchronous active-high reset, also clears statistics
//   start        in   debounced level, rising edge starts a trial
//   stop         in   debounced levels, one per player, rising edge = response
//   led          out  stimulus indicator
//   busy         out  high while waiting or timing
//   count        out  live tick count
//   times        out  latched result per player, player i at [i*CNT_W +: CNT_W]
//   foul         out  per-player early-press flags
//   winner       out  lowest index among the fastest players
//   winner_valid out  winner is meaningful (not every time saturated)
//   stat_min/max out  extreme player-0 results
//   stat_avg     out  truncated player-0 average
//   stat_cnt     out  number of trials in the statistics (saturates at 255)
//   avg_valid    out  stat_avg reflects the latest statistics
module reaction_timer_multi #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TICK_HZ      = 1000,
  parameter int unsigned MIN_DELAY_MS = 2000,
  parameter int unsigned MAX_DELAY_MS = 6000,
  parameter int unsigned MAX_COUNT    = 999,
  parameter int unsigned PLAYERS      = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int unsigned CNT_W       = $clog2(MAX_COUNT + 1),
  localparam int unsigned PW          = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic                     clk_50M,
  input  logic                     clear,
  input  logic                     start,
  input  logic [PLAYERS-1:0]       stop,
  output logic                     led,
  output logic                     busy,
  output logic [CNT_W-1:0]         count,
  output logic [PLAYERS*CNT_W-1:0] times,
  output logic [PLAYERS-1:0]       foul,
  output logic [PW-1:0]            winner,
  output logic                     winner_valid,
  output logic [CNT_W-1:0]         stat_min,
  output logic [CNT_W-1:0]         stat_max,
  output logic [CNT_W-1:0]         stat_avg,
  output logic [7:0]               stat_cnt,
  output logic                     avg_valid
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PSC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DLY_W    = $clog2(MAX_DELAY_MS + 1);
  localparam int unsigned RANGE    = MAX_DELAY_MS - MIN_DELAY_MS + 1;
  localparam int unsigned SUM_W    = CNT_W + 8;
  localparam int unsigned STEP_W   = $clog2(SUM_W + 1);
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(MAX_COUNT);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RUN, S_DONE, S_FOUL} state_t;

  state_t r_state, w_state_next;

  logic                     r_start_q;
  logic [PLAYERS-1:0]       r_stop_q;
  logic [15:0]              r_lfsr;
  logic [PSC_W-1:0]         r_psc;
  logic [DLY_W-1:0]         r_delay;
  logic [CNT_W-1:0]         r_count;
  logic [PLAYERS*CNT_W-1:0] r_times;
  logic [PLAYERS-1:0]       r_latched;
  logic [PLAYERS-1:0]       r_foul;
  logic [PW-1:0]            r_winner;
  logic                     r_wvalid;
  logic                     r_led;
  logic [CNT_W-1:0]         r_min, r_max, r_avg;
  logic [SUM_W-1:0]         r_sum;
  logic [7:0]               r_scnt;
  logic                     r_avg_valid;
  logic                     r_div_busy;
  logic [SUM_W-1:0]         r_dq;
  logic [7:0]               r_rem;
  logic [7:0]               r_dvs;
  logic [STEP_W-1:0]        r_div_left;

  logic                     w_start_edge;
  logic [PLAYERS-1:0]       w_stop_edge;
  logic                     w_tick;
  logic [47:0]              w_prod;
  logic [DLY_W-1:0]         w_delay_smp;
  logic [PLAYERS*CNT_W-1:0] w_times_n;
  logic [PLAYERS-1:0]       w_latched_n;
  logic                     w_count_hit;
  logic                     w_all_latched;
  logic [PW-1:0]            w_win;
  logic [CNT_W-1:0]         w_best;
  logic                     w_win_valid;
  logic                     w_go, w_to_run, w_to_done, w_to_foul;
  logic                     w_sat;
  logic [CNT_W-1:0]         w_v;
  logic [SUM_W-1:0]         w_sum_n;
  logic [7:0]               w_scnt_n;
  logic [8:0]               w_rs;
  logic                     w_ge;
  logic [7:0]               w_rem_n;
  logic [SUM_W-1:0]         w_dq_n;

  assign w_start_edge = start & ~r_start_q;
  assign w_stop_edge  = stop & ~r_stop_q;
  assign w_tick       = (r_psc == PSC_W'(TICK_DIV - 1));

  // Scale the LFSR value into [MIN, MAX] without a modulo.
  assign w_prod      = {32'd0, r_lfsr} * 48'(RANGE);
  assign w_delay_smp = DLY_W'(48'(MIN_DELAY_MS) + (w_prod >> 16));

  // Latch first edges at the pre-increment count; on saturation fill the rest.
  always_comb begin
    w_times_n   = r_times;
    w_latched_n = r_latched;
    w_count_hit = w_tick && (r_count == CMAX - CNT_W'(1));
    for (int unsigned i = 0; i < PLAYERS; i++) begin
      if (w_stop_edge[i] && !r_latched[i]) begin
        w_times_n[i*CNT_W +: CNT_W] = r_count;
        w_latched_n[i]              = 1'b1;
      end else if (w_count_hit && !r_latched[i]) begin
        w_times_n[i*CNT_W +: CNT_W] = CMAX;
      end
    end
    w_all_latched = &w_latched_n;
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    w_win  = '0;
    w_best = w_times_n[0 +: CNT_W];
    for (int unsigned i = 1; i < PLAYERS; i++) begin
      if (w_times_n[i*CNT_W +: CNT_W] < w_best) begin
        w_best = w_times_n[i*CNT_W +: CNT_W];
        w_win  = PW'(i);
      end
    end
    w_win_valid = (w_best != CMAX);
  end

  always_comb begin
    w_state_next = r_state;
    w_go         = 1'b0;
    w_to_run     = 1'b0;
    w_to_done    = 1'b0;
    w_to_foul    = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE, S_FOUL: begin
        if (w_start_edge) begin
          w_state_next = S_WAIT;
          w_go         = 1'b1;
        end
      end
      S_WAIT: begin
        if (|w_stop_edge) begin
          w_state_next = S_FOUL;
          w_to_foul    = 1'b1;
        end else if (w_tick && (r_delay == DLY_W'(1))) begin
          w_state_next = S_RUN;
          w_to_run     = 1'b1;
        end
      end
      S_RUN: begin
        if (w_all_latched || w_count_hit) begin
          w_state_next = S_DONE;
          w_to_done    = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_v      = w_times_n[0 +: CNT_W];
  assign w_sat    = (r_scnt == 8'hFF);
  assign w_sum_n  = w_sat ? r_sum : r_sum + SUM_W'(w_v);
  assign w_scnt_n = w_sat ? r_scnt : r_scnt + 8'd1;

  // Restoring division: dividend shifts out the top while quotient bits enter below.
  assign w_rs    = {r_rem, r_dq[SUM_W-1]};
  assign w_ge    = (w_rs >= {1'b0, r_dvs});
  assign w_rem_n = w_ge ? 8'(w_rs - {1'b0, r_dvs}) : w_rs[7:0];
  assign w_dq_n  = {r_dq[SUM_W-2:0], w_ge};

  always_ff @(posedge clk_50M) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk_50M) begin
    if (clear) begin
      // Held buttons must not look like fresh edges once clear releases.
      r_start_q   <= start;
      r_stop_q    <= stop;
      r_lfsr      <= LFSR_SEED;
      r_psc       <= '0;
      r_delay     <= '0;
      r_count     <= '0;
      r_times     <= '0;
      r_latched   <= '0;
      r_foul      <= '0;
      r_winner    <= '0;
      r_wvalid    <= 1'b0;
      r_led       <= 1'b0;
      r_min       <= CMAX;
      r_max       <= '0;
      r_avg       <= '0;
      r_sum       <= '0;
      r_scnt      <= '0;
      r_avg_valid <= 1'b0;
      r_div_busy  <= 1'b0;
      r_dq        <= '0;
      r_rem       <= '0;
      r_dvs       <= '0;
      r_div_left  <= '0;
    end else begin
      r_start_q <= start;
      r_stop_q  <= stop;
      r_lfsr    <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_psc     <= w_tick ? '0 : r_psc + PSC_W'(1);

      if (r_state == S_WAIT && w_tick) r_delay <= r_delay - DLY_W'(1);
      if (w_to_foul) r_foul <= w_stop_edge;
      if (w_to_run) begin
        r_led   <= 1'b1;
        r_count <= '0;
      end
      if (r_state == S_RUN) begin
        r_times   <= w_times_n;
        r_latched <= w_latched_n;
        if (w_tick && r_count != CMAX) r_count <= r_count + CNT_W'(1);
      end

      if (w_to_done) begin
        r_led       <= 1'b0;
        r_winner    <= w_win;
        r_wvalid    <= w_win_valid;
        r_sum       <= w_sum_n;
        r_scnt      <= w_scnt_n;
        if (!w_sat && w_v < r_min) r_min <= w_v;
        if (!w_sat && w_v > r_max) r_max <= w_v;
        r_avg_valid <= 1'b0;
        r_div_busy  <= 1'b1;
        r_dq        <= w_sum_n;
        r_rem       <= '0;
        r_dvs       <= w_scnt_n;
        r_div_left  <= STEP_W'(SUM_W);
      end else if (r_div_busy && !w_go) begin
        r_dq       <= w_dq_n;
        r_rem      <= w_rem_n;
        r_div_left <= r_div_left - STEP_W'(1);
        if (r_div_left == STEP_W'(1)) begin
          r_div_busy  <= 1'b0;
          r_avg       <= w_dq_n[CNT_W-1:0];
          r_avg_valid <= 1'b1;
        end
      end

      if (w_go) begin
        r_psc      <= '0;
        r_delay    <= w_delay_smp;
        r_count    <= '0;
        r_times    <= '0;
        r_latched  <= '0;
        r_foul     <= '0;
        r_wvalid   <= 1'b0;
        r_div_busy <= 1'b0;
      end
    end
  end

  assign led          = r_led;
  assign busy         = (r_state == S_WAIT) || (r_state == S_RUN);
  assign count        = r_count;
  assign times        = r_times;
  assign foul         = r_foul;
  assign winner       = r_winner;
  assign winner_valid = r_wvalid;
  assign stat_min     = r_min;
  assign stat_max     = r_max;
  assign stat_avg     = r_avg;
  assign stat_cnt     = r_scnt;
  assign avg_valid    = r_avg_valid;

endmodule

// File: tb/tb_reaction_timer_multi.sv
module tb_reaction_timer_multi;

  localparam int P    = 2;
  localparam int CW   = 10;
  localparam int MAXC = 999;
  localparam int TD   = 10;

  logic          clk_50M = 1'b0;
  logic          clear   = 1'b1;
  logic          start   = 1'b0;
  logic [P-1:0]  stop    = '0;
  logic          led, busy, winner_valid, avg_valid;
  logic [CW-1:0] count, stat_min, stat_max, stat_avg;
  logic [P*CW-1:0] times;
  logic [P-1:0]  foul;
  logic [0:0]    winner;
  logic [7:0]    stat_cnt;

  always #5 clk_50M = ~clk_50M;

  reaction_timer_multi #(
    .CLK_HZ(1000), .TICK_HZ(100), .MIN_DELAY_MS(2), .MAX_DELAY_MS(6),
    .MAX_COUNT(999), .PLAYERS(2), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_50M(clk_50M), .clear(clear), .start(start), .stop(stop),
    .led(led), .busy(busy), .count(count), .times(times), .foul(foul),
    .winner(winner), .winner_valid(winner_valid),
    .stat_min(stat_min), .stat_max(stat_max), .stat_avg(stat_avg),
    .stat_cnt(stat_cnt), .avg_valid(avg_valid)
  );

  typedef struct {
    int t0; int t1; logic [1:0] fl; bit done; int win; bit wv;
    int smin; int smax; int savg; int scnt;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   in_clear = 1'b0;
  int   m_min = MAXC, m_max = 0, m_sum = 0, m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_min = MAXC; m_max = 0; m_sum = 0; m_cnt = 0;
  endfunction

  function automatic void model_add(input int v);
    if (m_cnt < 255) begin
      if (v < m_min) m_min = v;
      if (v > m_max) m_max = v;
      m_sum += v;
      m_cnt++;
    end
  endfunction

  function automatic int model_avg();
    return (m_cnt == 0) ? 0 : m_sum / m_cnt;
  endfunction

  task automatic check_reset();
    chk("rst_led", 32'(led), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_times", 32'(times), 0);
    chk("rst_foul", 32'(foul), 0);
    chk("rst_winner", 32'(winner), 0);
    chk("rst_winner_valid", 32'(winner_valid), 0);
    chk("rst_stat_min", 32'(stat_min), MAXC);
    chk("rst_stat_max", 32'(stat_max), 0);
    chk("rst_stat_avg", 32'(stat_avg), 0);
    chk("rst_stat_cnt", 32'(stat_cnt), 0);
    chk("rst_avg_valid", 32'(avg_valid), 0);
  endtask

  // Scoreboard monitor: a trial's result is checked when busy falls.
  initial begin
    bit   pb;
    exp_t e;
    int   k;
    pb = 1'b0;
    forever begin
      @(posedge clk_50M); #1;
      if (pb && !busy && !in_clear) begin
        if (sbq.size() == 0) begin
          chk("unexpected_trial_end", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("times0", 32'(times[CW-1:0]), 32'(e.t0));
          chk("times1", 32'(times[2*CW-1:CW]), 32'(e.t1));
          chk("foul", 32'(foul), 32'(e.fl));
          chk("led_off", 32'(led), 0);
          chk("winner_valid", 32'(winner_valid), 32'(e.wv));
          if (e.done && e.wv) chk("winner", 32'(winner), 32'(e.win));
          if (e.done) chk("avg_valid_drop", 32'(avg_valid), 0);
          @(posedge clk_50M); #1;
          chk("stat_min", 32'(stat_min), 32'(e.smin));
          chk("stat_max", 32'(stat_max), 32'(e.smax));
          chk("stat_cnt", 32'(stat_cnt), 32'(e.scnt));
          if (e.done) begin
            k = 0;
            while (!avg_valid && k < 40) begin
              @(posedge clk_50M); #1;
              k++;
            end
            chk("avg_latency", 32'(1 + k), 32'(CW + 8));
            chk("stat_avg", 32'(stat_avg), 32'(e.savg));
          end
        end
      end
      pb = busy;
    end
  end

  task automatic start_and_wait();
    int len;
    len = 0;
    start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("led_in_wait", 32'(led), 0);
    while (!led && len < 100) begin
      @(negedge clk_50M);
      len++;
    end
    n_cmp++;
    if (len < 2 * TD || len > 6 * TD) begin
      n_bad++;
      $display("FAIL wait_len: got %0d cycles, expected 20..60", len);
    end
    chk("wait_len_tick_multiple", 32'(len % TD), 0);
    chk("count_at_run_entry", 32'(count), 0);
  endtask

  // j0/j1: cycles after LED rise at which each stop is raised; negative = never.
  task automatic trial(input int j0, input int j1, input bit hold0);
    exp_t e;
    if (hold0) begin
      stop[0] = 1'b1;
      repeat (3) @(negedge clk_50M);
    end
    e.t0 = (j0 < 0) ? MAXC : ((j0 / TD > MAXC) ? MAXC : j0 / TD);
    e.t1 = (j1 < 0) ? MAXC : ((j1 / TD > MAXC) ? MAXC : j1 / TD);
    e.fl = 2'b00;
    e.done = 1'b1;
    e.win = (e.t1 < e.t0) ? 1 : 0;
    e.wv = !(e.t0 == MAXC && e.t1 == MAXC);
    model_add(e.t0);
    e.smin = m_min; e.smax = m_max; e.savg = model_avg(); e.scnt = m_cnt;
    sbq.push_back(e);
    start_and_wait();
    for (int j = 0; j < 10100; j++) begin
      if (hold0 && j == 0) stop[0] = 1'b0;
      if (j == j0) stop[0] = 1'b1;
      if (j == j1) stop[1] = 1'b1;
      @(negedge clk_50M);
      if (!busy) break;
    end
    chk("trial_ends", 32'(busy), 0);
    if (j0 < 0 && j1 < 0) chk("count_saturated", 32'(count), MAXC);
    stop = '0;
    repeat (30 + $urandom_range(0, 20)) @(negedge clk_50M);
  endtask

  task automatic foul_trial(input logic [1:0] who);
    exp_t e;
    int   k;
    e.t0 = 0; e.t1 = 0; e.fl = who; e.done = 1'b0; e.win = 0; e.wv = 1'b0;
    e.smin = m_min; e.smax = m_max; e.savg = model_avg(); e.scnt = m_cnt;
    sbq.push_back(e);
    start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
    repeat ($urandom_range(0, 10)) @(negedge clk_50M);
    stop = who;
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk_50M);
      k++;
    end
    chk("foul_ends", 32'(busy), 0);
    stop = '0;
    repeat (30) @(negedge clk_50M);
  endtask

  task automatic do_clear();
    in_clear = 1'b1;
    clear = 1'b1;
    @(posedge clk_50M); #1;
    check_reset();
    @(negedge clk_50M);
    clear = 1'b0;
    in_clear = 1'b0;
    sbq.delete();
    model_reset();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int jt;
    repeat (3) @(negedge clk_50M);
    check_reset();
    clear = 1'b0;
    repeat (5) @(negedge clk_50M);

    trial(370 + $urandom_range(0, 9), 520 + $urandom_range(0, 9), 1'b0);

    do_clear();
    repeat (5) @(negedge clk_50M);
    trial(1000 + $urandom_range(0, 9), $urandom_range(0, 3500), 1'b0);
    trial(2000 + $urandom_range(0, 9), $urandom_range(0, 3500), 1'b0);
    trial(3010 + $urandom_range(0, 9), $urandom_range(0, 3500), 1'b0);

    foul_trial(2'b10);
    foul_trial(2'b11);

    jt = 250 + $urandom_range(0, 30);
    trial(jt, jt, 1'b1);

    trial(-1, -1, 1'b0);

    repeat (200) begin
      repeat ($urandom_range(0, 25)) @(negedge clk_50M);
      trial($urandom_range(0, 40), $urandom_range(0, 40), 1'b0);
    end

    start_and_wait();
    repeat (15) @(negedge clk_50M);
    do_clear();

    repeat (40) @(negedge clk_50M);
    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
